// File: rtl/ks10_arb_pkg.sv
// ks10_arb_pkg: shared types and constants for the KS10 backplane bus arbiter.
//   state_t     arbiter FSM states (IDLE, REQ, ACKWAIT, RELEASE)
//   ADDR_W/DATA_W/INTR_W  bus field widths
//   addr_t/data_t/intr_t  bus field types
//   idxWidth()  width of a device index for a given device count
// KS10 numbering puts bit 0 at the MSB. Vector bit [W-1] carries KS10 bit 0.
package ks10_arb_pkg;

    localparam int ADDR_W = 36;
    localparam int DATA_W = 36;
    localparam int INTR_W = 7;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [INTR_W-1:0] intr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACKWAIT = 2'd2,
        RELEASE = 2'd3
    } state_t;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ks10_arb_select.sv
// ks10_arb_select: combinational winner selection for the bus arbiter.
//   req     in   NDEV       request vector
//   ptr     in   idx        last winner (round-robin build only)
//   winner  out  idx        index of the selected requester
//   valid   out  1          at least one request is present
// Build option KS10_ARB_ROUND_ROBIN_EN: when defined, the search starts one
// above ptr and wraps modulo NDEV. When undefined, the lowest requesting
// index wins and there is no ptr port.
module ks10_arb_select
    import ks10_arb_pkg::*;
#(
    parameter int NDEV = 4
) (
    input  logic [NDEV-1:0]           req,
`ifdef KS10_ARB_ROUND_ROBIN_EN
    input  logic [idxWidth(NDEV)-1:0] ptr,
`endif
    output logic [idxWidth(NDEV)-1:0] winner,
    output logic                      valid
);

    localparam int IDX_W = idxWidth(NDEV);

`ifdef KS10_ARB_ROUND_ROBIN_EN
    int j;

    // Walk ptr+1 .. ptr+NDEV. The last visit is ptr itself, so a lone
    // requester that just finished is still served.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        j      = 0;
        for (int i = 1; i <= NDEV; i++) begin
            j = (int'(ptr) + i) % NDEV;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                winner = IDX_W'(j);
            end
        end
    end
`else
    // Scan downward so that the lowest requesting index is written last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid  = 1'b1;
                winner = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/ks10_bus_arbiter.sv
// ks10_bus_arbiter: central arbiter for the KS10 backplane bus.
// Sequence: grant (IDLE) -> one-cycle request strobe (REQ) -> wait for an
// acknowledge or timeout (ACKWAIT) -> hold until the master drops its
// request (RELEASE).
//   clk, rst       clock, asynchronous active-high reset
//   devREQO/ACKO   per-device request / acknowledge
//   devADDRO/DATAO per-device address / data (NDEV x 36)
//   devINTRO       per-device interrupt lines (NDEV x 7)
//   busREQI/ACKI   broadcast request / acknowledge strobes
//   busADDRI/DATAI broadcast address / data
//   busINTRI       registered OR of all interrupt lines
//   busGNT         one-hot grant
//   busNXD         pulse: no acknowledge within TIMEOUT cycles
//   busACKERR      pulse: more than one device acknowledged
// Build option KS10_ARB_ROUND_ROBIN_EN: use round-robin arbitration instead
// of fixed priority.
// All outputs are registered.
module ks10_bus_arbiter
    import ks10_arb_pkg::*;
#(
    parameter int NDEV    = 4,
    parameter int TIMEOUT = 63
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NDEV-1:0]              devREQO,
    input  logic [NDEV-1:0]              devACKO,
    input  logic [NDEV-1:0][ADDR_W-1:0]  devADDRO,
    input  logic [NDEV-1:0][DATA_W-1:0]  devDATAO,
    input  logic [NDEV-1:0][INTR_W-1:0]  devINTRO,
    output logic                         busREQI,
    output logic                         busACKI,
    output logic [ADDR_W-1:0]            busADDRI,
    output logic [DATA_W-1:0]            busDATAI,
    output logic [INTR_W-1:0]            busINTRI,
    output logic [NDEV-1:0]              busGNT,
    output logic                         busNXD,
    output logic                         busACKERR
);

    localparam int IDX_W = idxWidth(NDEV);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [CNT_W-1:0]  toCnt;
    logic [IDX_W-1:0]  gntIdx;
    logic [IDX_W-1:0]  winner;
    logic              winValid;
    logic [NDEV-1:0]   ackVec;
    logic              ackMulti;
    data_t             ackData;
    intr_t             intrOr;

`ifdef KS10_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]  rrPtr;

    ks10_arb_select #(.NDEV(NDEV)) uSel (
        .req    (devREQO),
        .ptr    (rrPtr),
        .winner (winner),
        .valid  (winValid)
    );
`else
    ks10_arb_select #(.NDEV(NDEV)) uSel (
        .req    (devREQO),
        .winner (winner),
        .valid  (winValid)
    );
`endif

    // The current master's own acknowledge bit is masked out. More than one
    // remaining bit set means colliding responders. Their data is OR'ed, as
    // it would be on a wired-OR backplane.
    always_comb begin
        ackVec   = devACKO & ~busGNT;
        ackMulti = |(ackVec & (ackVec - NDEV'(1)));
        ackData  = '0;
        intrOr   = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (ackVec[i]) ackData = ackData | devDATAO[i];
            intrOr = intrOr | devINTRO[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busINTRI <= '0;
        else     busINTRI <= intrOr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            toCnt     <= '0;
            gntIdx    <= '0;
            busREQI   <= 1'b0;
            busACKI   <= 1'b0;
            busNXD    <= 1'b0;
            busACKERR <= 1'b0;
            busGNT    <= '0;
            busADDRI  <= '0;
            busDATAI  <= '0;
`ifdef KS10_ARB_ROUND_ROBIN_EN
            rrPtr     <= IDX_W'(NDEV - 1);
`endif
        end else begin
            // Strobes default low, so each one lasts a single cycle.
            busREQI   <= 1'b0;
            busACKI   <= 1'b0;
            busNXD    <= 1'b0;
            busACKERR <= 1'b0;
            case (state)
                IDLE: begin
                    busGNT <= '0;
                    if (winValid) begin
                        busGNT[winner] <= 1'b1;
                        gntIdx         <= winner;
                        busADDRI       <= devADDRO[winner];
                        busDATAI       <= devDATAO[winner];
                        state          <= REQ;
                    end
                end
                REQ: begin
                    busREQI <= 1'b1;
                    toCnt   <= '0;
                    state   <= ACKWAIT;
                end
                ACKWAIT: begin
                    if (|ackVec) begin
                        // An acknowledge takes priority over a timeout in the same cycle.
                        busACKI   <= 1'b1;
                        busDATAI  <= ackData;
                        busACKERR <= ackMulti;
                        state     <= RELEASE;
                    end else begin
                        if (toCnt != CNT_W'(TIMEOUT)) toCnt <= toCnt + CNT_W'(1);
                        // Compare against the pre-increment value so the pulse
                        // fires on the cycle the count reaches TIMEOUT.
                        if (toCnt == CNT_W'(TIMEOUT - 1)) begin
                            busNXD   <= 1'b1;
                            busDATAI <= '0;
                            state    <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (!devREQO[gntIdx]) begin
                        busGNT <= '0;
`ifdef KS10_ARB_ROUND_ROBIN_EN
                        rrPtr  <= gntIdx;
`endif
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ks10_bus_arbiter.sv
// tb_ks10_bus_arbiter: directed bench for ks10_bus_arbiter.
// Expected bus requests and responses are queued as stimulus is driven. A
// negedge monitor compares them against each busREQI and each
// busACKI/busNXD/busACKERR strobe.
// Arbitration order depends on KS10_ARB_ROUND_ROBIN_EN.
module tb_ks10_bus_arbiter;
    import ks10_arb_pkg::*;

    localparam int NDEV    = 4;
    localparam int TIMEOUT = 63;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NDEV-1:0]             devREQO, devACKO;
    logic [NDEV-1:0][ADDR_W-1:0] devADDRO;
    logic [NDEV-1:0][DATA_W-1:0] devDATAO;
    logic [NDEV-1:0][INTR_W-1:0] devINTRO;
    logic                        busREQI, busACKI, busNXD, busACKERR;
    logic [ADDR_W-1:0]           busADDRI;
    logic [DATA_W-1:0]           busDATAI;
    logic [INTR_W-1:0]           busINTRI;
    logic [NDEV-1:0]             busGNT;

    addr_t devAddr [NDEV];
    data_t devData [NDEV];

    int checks   = 0;
    int failures = 0;

    typedef struct { logic [NDEV-1:0] gnt; addr_t addr; data_t data; } reqExp_t;
    typedef struct { logic ack; logic nxd; logic err; data_t data; } rspExp_t;
    reqExp_t reqQ[$];
    rspExp_t rspQ[$];

    ks10_bus_arbiter #(.NDEV(NDEV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .devREQO(devREQO), .devACKO(devACKO), .devADDRO(devADDRO),
        .devDATAO(devDATAO), .devINTRO(devINTRO),
        .busREQI(busREQI), .busACKI(busACKI), .busADDRI(busADDRI),
        .busDATAI(busDATAI), .busINTRI(busINTRI), .busGNT(busGNT),
        .busNXD(busNXD), .busACKERR(busACKERR)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NDEV; i++) begin
            devADDRO[i] = devAddr[i];
            devDATAO[i] = devData[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitReq(input string tag);
        int n = 0;
        while (busREQI !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        chk({tag, "_reqseen"}, 64'(busREQI), 64'd1);
    endtask

    task automatic pushReq(input int w);
        reqExp_t e;
        e.gnt    = '0;
        e.gnt[w] = 1'b1;
        e.addr   = devAddr[w];
        e.data   = devData[w];
        reqQ.push_back(e);
    endtask

    task automatic pushRsp(input logic ack, input logic nxd, input logic err, input data_t d);
        rspExp_t r;
        r.ack = ack; r.nxd = nxd; r.err = err; r.data = d;
        rspQ.push_back(r);
    endtask

    // Call with the arbiter idle and the master's request already raised.
    // Completes one acknowledged transaction and drops the master's request.
    task automatic doTxn(input int w, input logic [NDEV-1:0] ackVec, input data_t expData,
                         input logic expErr, input string tag);
        logic [NDEV-1:0] g;
        g = '0;
        g[w] = 1'b1;
        pushReq(w);
        waitReq(tag);
        chk({tag, "_gnt"}, 64'(busGNT), 64'(g));
        devACKO = ackVec;
        pushRsp(1'b1, 1'b0, expErr, expData);
        tick(1);
        chk({tag, "_ack"}, 64'(busACKI), 64'd1);
        chk({tag, "_ackerr"}, 64'(busACKERR), 64'(expErr));
        chk({tag, "_data"}, 64'(busDATAI), 64'(expData));
        devACKO    = '0;
        devREQO[w] = 1'b0;
        tick(1);
        chk({tag, "_rel"}, 64'(busGNT), 64'd0);
        chk({tag, "_errpulse"}, 64'(busACKERR), 64'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : mon
        reqExp_t e;
        rspExp_t r;
        if (rst === 1'b0) begin
            if (busREQI === 1'b1) begin
                if (reqQ.size() == 0) chk("sb_req_unexpected", 64'd1, 64'd0);
                else begin
                    e = reqQ.pop_front();
                    chk("sb_gnt", 64'(busGNT), 64'(e.gnt));
                    chk("sb_addr", 64'(busADDRI), 64'(e.addr));
                    chk("sb_mdata", 64'(busDATAI), 64'(e.data));
                end
            end
            if (busACKI === 1'b1 || busNXD === 1'b1 || busACKERR === 1'b1) begin
                if (rspQ.size() == 0) chk("sb_rsp_unexpected", 64'd1, 64'd0);
                else begin
                    r = rspQ.pop_front();
                    chk("sb_ack", 64'(busACKI), 64'(r.ack));
                    chk("sb_nxd", 64'(busNXD), 64'(r.nxd));
                    chk("sb_ackerr", 64'(busACKERR), 64'(r.err));
                    chk("sb_rdata", 64'(busDATAI), 64'(r.data));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic sawNxd, sawGnt;
        rst      = 1'b1;
        devREQO  = '0;
        devACKO  = '0;
        devINTRO = '0;
        for (int i = 0; i < NDEV; i++) begin
            devAddr[i] = 36'o100000 + 36'(i);
            devData[i] = 36'o200000 + 36'(i);
        end
        devAddr[1] = 36'o000000_001234;

        // Reset state
        tick(2);
        chk("rst_gnt", 64'(busGNT), 64'd0);
        chk("rst_req", 64'(busREQI), 64'd0);
        chk("rst_ack", 64'(busACKI), 64'd0);
        chk("rst_addr", 64'(busADDRI), 64'd0);
        chk("rst_data", 64'(busDATAI), 64'd0);
        chk("rst_intr", 64'(busINTRI), 64'd0);
        chk("rst_nxd", 64'(busNXD), 64'd0);
        chk("rst_ackerr", 64'(busACKERR), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);

        // Arbitration: dev0+dev3 together, then dev0 re-requests while dev3 waits
        devREQO = 4'b1001;
        doTxn(0, 4'b0100, devData[2], 1'b0, "t2a");
        devREQO[0] = 1'b1;
`ifdef KS10_ARB_ROUND_ROBIN_EN
        doTxn(3, 4'b0100, devData[2], 1'b0, "t2b");
        doTxn(0, 4'b0100, devData[2], 1'b0, "t2c");
`else
        doTxn(0, 4'b0100, devData[2], 1'b0, "t2b");
        doTxn(3, 4'b0100, devData[2], 1'b0, "t2c");
`endif

        // Single read: dev1 master, dev2 acks 3 cycles after busREQI
        devREQO[1] = 1'b1;
        pushReq(1);
        tick(1);
        chk("t1_gnt", 64'(busGNT), 64'b0010);
        chk("t1_req_early", 64'(busREQI), 64'd0);
        tick(1);
        chk("t1_req", 64'(busREQI), 64'd1);
        devACKO[1] = 1'b1;   // master's own ack must be ignored
        tick(1);
        chk("t1_req_pulse", 64'(busREQI), 64'd0);
        chk("t1_selfack", 64'(busACKI), 64'd0);
        tick(1);
        chk("t1_selfack2", 64'(busACKI), 64'd0);
        devACKO    = 4'b0100;
        devData[2] = 36'o123456_654321;
        pushRsp(1'b1, 1'b0, 1'b0, 36'o123456_654321);
        tick(1);
        chk("t1_ack", 64'(busACKI), 64'd1);
        chk("t1_rdata", 64'(busDATAI), 64'(36'o123456_654321));
        devACKO = '0;
        tick(1);
        chk("t1_ack_pulse", 64'(busACKI), 64'd0);
        chk("t1_hold", 64'(busGNT), 64'b0010);
        tick(2);
        chk("t1_hold2", 64'(busGNT), 64'b0010);
        devREQO[1] = 1'b0;
        tick(1);
        chk("t1_rel", 64'(busGNT), 64'd0);
        devData[2] = 36'o200002;

        // Timeout with interrupts raised mid-ACKWAIT
        devREQO[2] = 1'b1;
        pushReq(2);
        pushRsp(1'b0, 1'b1, 1'b0, 36'd0);
        waitReq("t3");
        tick(10);
        chk("t3_intr_pre", 64'(busINTRI), 64'd0);
        devINTRO[0] = 7'b0000001;
        devINTRO[3] = 7'b1000000;
        #1;
        chk("t3_intr_lat", 64'(busINTRI), 64'd0);
        tick(1);
        chk("t3_intr", 64'(busINTRI), 64'b1000001);
        tick(51);
        chk("t3_nxd_early", 64'(busNXD), 64'd0);
        tick(1);
        chk("t3_nxd", 64'(busNXD), 64'd1);
        chk("t3_noack", 64'(busACKI), 64'd0);
        chk("t3_data0", 64'(busDATAI), 64'd0);
        tick(1);
        chk("t3_nxd_pulse", 64'(busNXD), 64'd0);
        chk("t3_hold", 64'(busGNT), 64'b0100);
        chk("t3_data_hold", 64'(busDATAI), 64'd0);
        devREQO[2] = 1'b0;
        tick(1);
        chk("t3_rel", 64'(busGNT), 64'd0);

        // Double ack
        devData[1] = 36'o1;
        devData[2] = 36'o2;
        devREQO[0] = 1'b1;
        doTxn(0, 4'b0110, 36'o3, 1'b1, "t4");
        devData[1] = 36'o200001;
        devData[2] = 36'o200002;

        // Asynchronous reset in ACKWAIT
        devREQO[1] = 1'b1;
        pushReq(1);
        waitReq("t5");
        tick(3);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_gnt", 64'(busGNT), 64'd0);
        chk("t5_req", 64'(busREQI), 64'd0);
        chk("t5_addr", 64'(busADDRI), 64'd0);
        chk("t5_data", 64'(busDATAI), 64'd0);
        chk("t5_intr", 64'(busINTRI), 64'd0);
        chk("t5_nxd", 64'(busNXD), 64'd0);
        devREQO  = '0;
        devINTRO = '0;
        @(negedge clk);
        rst = 1'b0;
        sawNxd = 1'b0;
        sawGnt = 1'b0;
        for (int i = 0; i < TIMEOUT + 8; i++) begin
            tick(1);
            if (busNXD !== 1'b0) sawNxd = 1'b1;
            if (busGNT !== '0) sawGnt = 1'b1;
        end
        chk("t5_no_nxd", 64'(sawNxd), 64'd0);
        chk("t5_idle", 64'(sawGnt), 64'd0);
        // Pointer restarts at NDEV-1, so dev0 wins in either arbitration mode.
        devREQO = 4'b1001;
        doTxn(0, 4'b0100, devData[2], 1'b0, "t5b");
        doTxn(3, 4'b0100, devData[2], 1'b0, "t5c");

        tick(2);
        chk("sb_req_drained", 64'(reqQ.size()), 64'd0);
        chk("sb_rsp_drained", 64'(rspQ.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ks10_bus_arbiter.md
Name: ks10_bus_arbiter

Overview:
- Central arbiter for the KS10 backplane bus; drives the arbiter side of the ks10bus interface.
- Collects request, address, data, acknowledge and interrupt outputs from NDEV attached devices.
- Grants one master per transaction, broadcasts its request/address/data, and returns the responder's acknowledge and data.
- Times out unacknowledged requests as non-existent device (NXD) and ORs all interrupt lines onto the shared interrupt bus.

Parameters:
- NDEV, 4, number of attached devices; index 0 is highest fixed priority.
- TIMEOUT, 63, cycles to wait in ACKWAIT for an acknowledge before declaring NXD (1..1023).

Ports:
- clk  in  1  bus clock
- rst  in  1  reset, asynchronous, active-high
- devREQO  in  NDEV  per-device request out
- devACKO  in  NDEV  per-device acknowledge out
- devADDRO  in  NDEVx36  per-device address out, bit 0 is MSB
- devDATAO  in  NDEVx36  per-device data out
- devINTRO  in  NDEVx7  per-device interrupt out, bits 1..7
- busREQI  out  1  broadcast request
- busACKI  out  1  broadcast acknowledge
- busADDRI  out  36  broadcast address
- busDATAI  out  36  broadcast data
- busINTRI  out  7  broadcast interrupt, OR of all devINTRO
- busGNT  out  NDEV  one-hot current grant
- busNXD  out  1  one-cycle pulse on acknowledge timeout
- busACKERR  out  1  one-cycle pulse when more than one device acknowledges in the same cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state:
  - All outputs are 0 and the state is IDLE.
  - The round-robin pointer is NDEV-1, so device 0 wins first.
  - Assertion mid-transaction aborts immediately. No NXD or ACK is emitted.
- All outputs are registered.
- State machine: IDLE -> REQ -> ACKWAIT -> RELEASE -> IDLE.
- IDLE:
  - When any devREQO is set, the selector picks winner w.
  - Register busGNT=1<<w, busADDRI=devADDRO[w] and busDATAI=devDATAO[w], then go to REQ.
  - With no request, stay in IDLE with busGNT=0.
- REQ:
  - busREQI=1 for exactly one cycle, issued the cycle after the grant, so request latency is 2 clocks.
  - Address and data are held.
  - Clear the timeout counter and go to ACKWAIT.
- ACKWAIT:
  - Ignore devACKO[w], since a master never acknowledges itself.
  - On any other ack bit set: busACKI=1 for one cycle and busDATAI = bitwise OR of devDATAO over all acking devices; go to RELEASE.
  - If the ack vector is not one-hot, also pulse busACKERR.
  - Otherwise increment the counter. When it reaches TIMEOUT, pulse busNXD, set busDATAI=0 and go to RELEASE.
  - If an ack and the timeout coincide in the same cycle, the ack wins and there is no NXD.
- RELEASE:
  - busREQI=0 and busACKI=0; address and data are held.
  - Wait until devREQO[w]=0, then clear busGNT, update the round-robin pointer to w and return to IDLE.
  - Minimum of 1 cycle in RELEASE, so there is no back-to-back grant within the same cycle.
- Requests that arrive during a transaction are held by their devices and arbitrated in the next IDLE.
- A device dropping devREQO mid-transaction has no effect until RELEASE.
- busINTRI: registered OR of all devINTRO, updated every cycle independently of the FSM (1-cycle latency).
- Timeout counter width is clog2(TIMEOUT+1) and it saturates; it never wraps.

Optional Feature:
- KS10_ARB_ROUND_ROBIN_EN defined:
  - The winner is the first requesting index after the pointer, searching upward modulo NDEV.
  - No device is starved.
- Undefined:
  - Fixed priority: lowest requesting index wins.
  - The pointer is not implemented.

Decomposition:
- Package ks10_arb_pkg:
  - state enum (IDLE, REQ, ACKWAIT, RELEASE)
  - constants ADDR_W=36, DATA_W=36, INTR_W=7
  - typedefs addr_t, data_t, intr_t
- Sub-module ks10_arb_select: combinational.
  - Inputs: request vector and pointer.
  - Outputs: winner index and valid.
  - Contains the round-robin/fixed-priority mux under the macro.

Test Plan:
- Single read: dev1 requests addr 36'o000000_001234; dev2 acks 3 cycles after busREQI with data 36'o123456_654321 -> busREQI high for 1 cycle 2 clocks after devREQO; busACKI for 1 cycle with that data; busGNT=4'b0010 until dev1 drops its request.
- Arbitration: dev0 and dev3 request in the same cycle -> dev0 granted first, dev3 second. With KS10_ARB_ROUND_ROBIN_EN, a repeated dev0+dev3 request after that yields dev3 before dev0.
- Timeout: TIMEOUT=63, request with no ack -> busNXD pulses exactly 63 cycles after entering ACKWAIT, busACKI stays 0, busDATAI=0, and the FSM returns to IDLE after the master drops its request.
- Double ack: dev1 and dev2 ack together with 36'o1 and 36'o2 -> busACKI=1, busACKERR=1, busDATAI=36'o3.
- Interrupts: dev0 INTRO=7'b0000001 and dev3 INTRO=7'b1000000 -> busINTRI=7'b1000001 one cycle later, including while in ACKWAIT.
- Reset in ACKWAIT: assert rst asynchronously mid-cycle -> all outputs 0 immediately and no NXD pulse; state is IDLE after deassertion.
